// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   stage and the multi-cycle unit's result return path. The pipeline has
//   priority; a starvation counter forces a grant to the multi-cycle unit after
//   STARVE_MAX consecutive denied cycles. The chosen write is registered, so the
//   register file sees at most one clean write per cycle.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data     pipeline write request
//   pipe_ready                       pipeline write accepted this cycle
//   mc_valid/mc_rd/mc_data           multi-cycle unit write request
//   mc_ready                         multi-cycle write accepted this cycle
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   starve_cnt                       current mc starvation count (debug)
//   forced_cnt                       forced mc grants since reset (saturating)
module wb_port_arbiter #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_ready,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        starve_cnt,
  output logic [7:0]        forced_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    S_NORM,
    S_FORCE
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        starve_reg, starve_next;
  logic [7:0]        forced_reg, forced_next;
  logic              pipe_grant, mc_grant;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;

  // Grant selection and next-state logic. Grants are suppressed while rst is
  // high so neither requester believes a write was accepted during reset.
  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    forced_next = forced_reg;
    pipe_grant  = 1'b0;
    mc_grant    = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_NORM: begin
          if (pipe_valid) begin
            pipe_grant = 1'b1;
          end else if (mc_valid) begin
            mc_grant = 1'b1;
          end
          if (!mc_valid || mc_grant) begin
            starve_next = 4'd0;
          end else if (starve_reg < STARVE_LIM) begin
            starve_next = starve_reg + 4'd1;
          end
          // Enter S_FORCE on the edge where the count reaches the limit, so
          // the forced grant lands in the very next cycle.
          if (starve_next == STARVE_LIM) begin
            state_next = S_FORCE;
          end
        end
        S_FORCE: begin
          if (mc_valid) begin
            mc_grant = 1'b1;
            if (forced_reg != 8'hFF) begin
              forced_next = forced_reg + 8'd1;
            end
          end else begin
            // mc withdrew its request: no forced grant, pipe served normally
            pipe_grant = pipe_valid;
          end
          starve_next = 4'd0;
          state_next  = S_NORM;
        end
        default: begin
          state_next  = S_NORM;
          starve_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_NORM;
      starve_reg <= 4'd0;
      forced_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      forced_reg <= forced_next;
    end
  end

  // Registered write port: address/data hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= pipe_grant | mc_grant;
      if (mc_grant) begin
        rf_waddr_reg <= mc_rd;
        rf_wdata_reg <= mc_data;
      end else if (pipe_grant) begin
        rf_waddr_reg <= pipe_rd;
        rf_wdata_reg <= pipe_data;
      end
    end
  end

  assign pipe_ready = pipe_grant;
  assign mc_ready   = mc_grant;
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;
  assign starve_cnt = starve_reg;
  assign forced_cnt = forced_reg;

endmodule
